// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and init-mode constants for the register file
package regfile_pkg;
  typedef enum logic [1:0] {RESET_HOLD, INIT, READY} rf_state_t;
  localparam int RF_INIT_ZERO  = 0;
  localparam int RF_INIT_INDEX = 1;
endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: sequences array initialisation one entry per cycle and owns ready
module regfile_init_seq import regfile_pkg::*; #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int INIT_MODE = RF_INIT_ZERO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);
  rf_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  // state and pointer registers; reset aborts any running init
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_HOLD;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end
  // next state: the last entry is at the all-ones pointer, so the increment wraps back to 0
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      RESET_HOLD: begin
        w_state_nxt = INIT;
        w_ptr_nxt   = '0;
      end
      INIT: begin
        w_ptr_nxt   = r_ptr + 1'b1;
        w_state_nxt = (r_ptr == '1) ? READY : INIT;
      end
      READY: begin
        w_state_nxt = clear_req ? INIT : READY;
        w_ptr_nxt   = clear_req ? '0 : r_ptr;
      end
      default: w_state_nxt = RESET_HOLD;
    endcase
  end
  assign ready     = (r_state == READY);
  assign init_we   = (r_state == INIT);
  assign init_addr = r_ptr;
  assign init_data = (INIT_MODE == RF_INIT_INDEX) ? DATA_W'(r_ptr) : '0;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with forwarding, zero register and init engine
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = RF_INIT_ZERO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     ready,
  output logic                     wr_collision
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic [DATA_W-1:0] w_init_data;
  logic [NUM_WR-1:0] w_commit;
  logic              w_coll;
  regfile_init_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_MODE(INIT_MODE)) u_init (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .ready     (ready),
    .init_we   (w_init_we),
    .init_addr (w_init_addr),
    .init_data (w_init_data)
  );
  // a user write commits only in READY without a clear, and never into the hardwired zero entry
  always_comb begin
    w_commit = '0;
    for (int w = 0; w < NUM_WR; w++)
      w_commit[w] = ready && !clear_req && wr_en[w] &&
                    !(ZERO_REG != 0 && wr_addr[w*ADDR_W +: ADDR_W] == '0);
  end
  // any pair of enabled ports aiming at the same address is a collision
  always_comb begin
    w_coll = 1'b0;
    for (int a = 0; a < NUM_WR; a++)
      for (int b = a + 1; b < NUM_WR; b++)
        if (wr_en[a] && wr_en[b] && wr_addr[a*ADDR_W +: ADDR_W] == wr_addr[b*ADDR_W +: ADDR_W])
          w_coll = 1'b1;
  end
  // collision flag is held for the cycle after the offending writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_collision <= 1'b0;
    else     wr_collision <= w_coll;
  end
  // array write; init and user writes never overlap, and later ports override earlier ones
  always_ff @(posedge clk) begin
    if (w_init_we) r_mem[w_init_addr] <= w_init_data;
    for (int w = 0; w < NUM_WR; w++)
      if (w_commit[w]) r_mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_q;
    assign w_a = rd_addr[k*ADDR_W +: ADDR_W];
    // read mux: not-ready and zero entry force 0, else highest committing matching port, else array
    always_comb begin
      w_q = r_mem[w_a];
      for (int w = 0; w < NUM_WR; w++)
        if (w_commit[w] && wr_addr[w*ADDR_W +: ADDR_W] == w_a) w_q = wr_data[w*DATA_W +: DATA_W];
      w_q = (!ready || (ZERO_REG != 0 && w_a == '0)) ? '0 : w_q;
    end
    assign rd_data[k*DATA_W +: DATA_W] = w_q;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined core's decode/write-back stages. It replaces the fixed 32x32, 2-read/1-write file. The block adds:
- configurable width, depth and port counts;
- same-cycle write-to-read forwarding;
- a hardwired zero register;
- a sequenced initialisation engine that fills the array one entry per cycle after reset, or on a runtime clear request, and holds `ready` low while it runs.

## Interface
- `DATA_W`, 32, data width in bits
- `ADDR_W`, 5, address width; DEPTH = 2**ADDR_W
- `NUM_RD`, 2, number of read ports (1..4)
- `NUM_WR`, 1, number of write ports (1..2)
- `ZERO_REG`, 1, 1 = entry 0 reads 0 and ignores writes
- `INIT_MODE`, 0, 0 = init every entry to 0; 1 = init entry i to i (zero-extended)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `clear_req`  in  1  request runtime re-initialisation (single-cycle pulse or level)
- `rd_addr`  in  NUM_RD*ADDR_W  read addresses, port k in bits [k*ADDR_W +: ADDR_W]
- `rd_data`  out  NUM_RD*DATA_W  read data, combinational
- `wr_en`  in  NUM_WR  per-port write enable
- `wr_addr`  in  NUM_WR*ADDR_W  write addresses
- `wr_data`  in  NUM_WR*DATA_W  write data
- `ready`  out  1  high when the array is initialised and accepts writes
- `wr_collision`  out  1  registered flag: previous cycle had two enabled writes to the same address

## Operation
- States are RESET_HOLD, INIT and READY.
  - `rst` high forces RESET_HOLD, init pointer 0, `ready`=0, `wr_collision`=0.
  - The array itself is not reset. It is uninitialised until INIT completes.
- RESET_HOLD goes to INIT on the first posedge after `rst` deasserts.
- INIT, at each posedge:
  - writes the init value to entry ptr, then ptr increments;
  - at ptr=DEPTH-1 it writes the last entry and goes to READY;
  - if ZERO_REG=1, the entry-0 write is still performed with value 0.
- READY:
  - if `clear_req` is high, goes to INIT with ptr=0, and all user writes that cycle are dropped;
  - otherwise user writes commit.
- `clear_req` is ignored in INIT and RESET_HOLD. It does not restart a running init.
- User writes while `ready`=0 are dropped silently.
- Write commit rule: port w commits when `wr_en[w]`=1, and not (ZERO_REG=1 and `wr_addr[w]`=0).
- Write conflict: when two ports write the same address, the higher port index wins. `wr_collision` is 1 on the following cycle for exactly one cycle.
- Read port k, in priority order:
  1. `ready`=0 gives 0.
  2. ZERO_REG=1 and addr=0 gives 0.
  3. If a committing write this cycle targets the same address, the forwarded `wr_data` (highest matching port) is returned.
  4. Otherwise the array contents.
- Forwarding is suppressed when `clear_req` drops the writes.
- All data is unsigned with no width conversion. For INIT_MODE=1, the index is zero-extended to DATA_W, or truncated if DATA_W < ADDR_W.

## Timing
- Reset values: `ready`=0, `wr_collision`=0, `rd_data`=0.
- Init latency: `ready` rises exactly DEPTH+1 posedges after `rst` falls. The first edge is RESET_HOLD to INIT, then DEPTH entry writes.
- Runtime clear: `ready` falls on the edge that samples `clear_req`, then rises DEPTH edges later.
- Write-to-read:
  - 0 cycles through forwarding, combinational in the same cycle;
  - from the array, the next cycle.
- Write commit happens at posedge. This changes the legacy negedge write; the forwarding path covers the half-cycle the legacy scheme provided.
- `rst` asserted mid-INIT aborts immediately. After deassertion, init restarts from ptr=0.
- No combinational path from `clear_req` to `rd_data` other than through forwarding suppression.

## Structure
- Package `regfile_pkg` holds:
  - the state enum `rf_state_t` (RESET_HOLD, INIT, READY);
  - INIT_MODE constants `RF_INIT_ZERO`=0 and `RF_INIT_INDEX`=1.
- Sub-module `regfile_init_seq`:
  - contains the FSM, ptr counter and `ready`;
  - outputs `init_we`, `init_addr` and `init_data`;
  - the top muxes init writes over user writes.
- The top holds the array, the write-port priority logic, forwarding muxes, the zero-register gating and the `wr_collision` flop.
- Use a generate loop over NUM_RD read ports.

## Test plan
- Reset and init, defaults, INIT_MODE=1. Pulse `rst`, then count edges → `ready` rises at edge 33; reads return 0 before that; `rd_addr`=7 then reads 7.
- Forwarding. With `ready`, write addr 5 = 0xDEADBEEF while reading addr 5 on both read ports the same cycle → both ports show 0xDEADBEEF in that cycle; the next cycle still shows 0xDEADBEEF.
- Zero register. Write addr 0 = 0x1234 → a read of addr 0 returns 0 in the same and the next cycle. Repeat with ZERO_REG=0 → 0x1234.
- Dual-write conflict, NUM_WR=2. Both ports write addr 9 (port0 = 0xA, port1 = 0xB) → the read shows 0xB; `wr_collision`=1 for exactly one cycle after.
- Runtime clear. In READY, assert `clear_req` together with a write of addr 3 = 0x55 → the write is dropped; `ready`=0 for 32 cycles; afterwards addr 3 reads 0 (INIT_MODE=0); `clear_req` held during INIT causes no restart.
- Reset mid-init. Assert `rst` at ptr=10 → `ready` stays 0; after release, init takes the full DEPTH+1 edges again.
